// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the game level sequencer.
package game_ctrl_pkg;

  localparam int unsigned LEVEL_W = 2;
  localparam int unsigned TRIES_W = 3;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned SW_W    = 2;
  localparam int unsigned SW1_BIT = 0;
  localparam int unsigned SW2_BIT = 1;

  localparam logic [LEVEL_W-1:0] LEVEL_IDLE  = LEVEL_W'(0);
  localparam logic [LEVEL_W-1:0] LEVEL_FIRST = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST  = LEVEL_W'(3);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_SETTLE,
    ST_CHECK,
    ST_WON,
    ST_LOST
  } state_t;

  // SWITCH1 unlocks from level 2, SWITCH2 only on the last level.
  function automatic logic [SW_W-1:0] mask_sw(input logic [LEVEL_W-1:0] level,
                                               input logic [SW_W-1:0]    req);
    logic [SW_W-1:0] m;
    m          = '0;
    m[SW1_BIT] = req[SW1_BIT] && (level >= LEVEL_W'(2));
    m[SW2_BIT] = req[SW2_BIT] && (level == LEVEL_LAST);
    return m;
  endfunction

endpackage

// File: rtl/game_level_sequencer_if.sv
// Control/status bundle between the game host and the level sequencer.
interface game_level_sequencer_if;
  import game_ctrl_pkg::*;

  logic                 start;
  logic                 abort;
  logic [2:0]           pass_in;
  logic [SW_W-1:0]      sw_req;
  logic                 draw;
  logic [LEVEL_W-1:0]   level_sel;
  logic [SW_W-1:0]      sw_cfg;
  logic [TRIES_W-1:0]   tries;
  logic [SCORE_W-1:0]   score;
  logic                 busy;
  logic                 game_won;
  logic                 game_lost;

  modport master (
    output start, abort, pass_in, sw_req,
    input  draw, level_sel, sw_cfg, tries, score, busy, game_won, game_lost
  );

  modport slave (
    input  start, abort, pass_in, sw_req,
    output draw, level_sel, sw_cfg, tries, score, busy, game_won, game_lost
  );
endinterface

// File: rtl/game_settle_timer.sv
// Loadable 4-bit down-counter timing the SETTLE wait.
module game_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done_c
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Done on the last settle cycle so the FSM leaves after exactly load_val cycles.
  assign done_c = (cnt <= 4'd1);

endmodule

// File: rtl/game_level_sequencer.sv
// Runs a game through levels 1..3: draw, settle, check, retry, score, gate switches.
module game_level_sequencer
  import game_ctrl_pkg::*;
#(
  parameter int unsigned MAX_TRIES  = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  game_level_sequencer_if.slave  bus
);

  state_t               state, state_n;
  logic [LEVEL_W-1:0]   level_q, level_n;
  logic [SW_W-1:0]      sw_q, sw_n;
  logic [TRIES_W-1:0]   tries_q, tries_n;
  logic [SCORE_W-1:0]   score_q, score_n;
  logic                 draw_q, draw_n;
  logic                 busy_q, busy_n;
  logic                 won_q, won_n;
  logic                 lost_q, lost_n;
  logic                 settle_done_c;
  logic                 pass_c;
  logic [SCORE_W:0]     score_sum_c;

  game_settle_timer u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_DRAW),
    .load_val (4'(SETTLE_CYC)),
    .en       (state == ST_SETTLE),
    .done_c   (settle_done_c)
  );

  always_comb begin
    pass_c = 1'b0;
    case (level_q)
      LEVEL_W'(1): pass_c = bus.pass_in[0];
      LEVEL_W'(2): pass_c = bus.pass_in[1];
      LEVEL_W'(3): pass_c = bus.pass_in[2];
      default:     pass_c = 1'b0;
    endcase
  end

  // Earlier clears earn more: MAX_TRIES - tries + 1 points.
  assign score_sum_c = {1'b0, score_q} + (SCORE_W+1)'(MAX_TRIES + 1 - 32'(tries_q));

  always_comb begin
    state_n = state;
    level_n = level_q;
    sw_n    = sw_q;
    tries_n = tries_q;
    score_n = score_q;
    won_n   = won_q;
    lost_n  = lost_q;

    if (bus.abort) begin
      state_n = ST_IDLE;
      level_n = LEVEL_IDLE;
      sw_n    = '0;
      tries_n = '0;
      won_n   = 1'b0;
      lost_n  = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_WON, ST_LOST: begin
          if (bus.start) begin
            state_n = ST_DRAW;
            level_n = LEVEL_FIRST;
            tries_n = '0;
            score_n = '0;
            won_n   = 1'b0;
            lost_n  = 1'b0;
          end
        end
        ST_DRAW: begin
          tries_n = tries_q + TRIES_W'(1);
          sw_n    = mask_sw(level_q, bus.sw_req);
          state_n = (SETTLE_CYC == 0) ? ST_CHECK : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_done_c) state_n = ST_CHECK;
        end
        ST_CHECK: begin
          if (pass_c) begin
            score_n = score_sum_c[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_c[SCORE_W-1:0];
            if (level_q == LEVEL_LAST) begin
              state_n = ST_WON;
              won_n   = 1'b1;
            end else begin
              state_n = ST_DRAW;
              level_n = level_q + LEVEL_W'(1);
              tries_n = '0;
            end
          end else if (tries_q == TRIES_W'(MAX_TRIES)) begin
            state_n = ST_LOST;
            lost_n  = 1'b1;
          end else begin
            state_n = ST_DRAW;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    draw_n = (state_n == ST_DRAW);
    busy_n = (state_n == ST_DRAW) || (state_n == ST_SETTLE) || (state_n == ST_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      level_q <= LEVEL_IDLE;
      sw_q    <= '0;
      tries_q <= '0;
      score_q <= '0;
      draw_q  <= 1'b0;
      busy_q  <= 1'b0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state   <= state_n;
      level_q <= level_n;
      sw_q    <= sw_n;
      tries_q <= tries_n;
      score_q <= score_n;
      draw_q  <= draw_n;
      busy_q  <= busy_n;
      won_q   <= won_n;
      lost_q  <= lost_n;
    end
  end

  assign bus.draw      = draw_q;
  assign bus.level_sel = level_q;
  assign bus.sw_cfg    = sw_q;
  assign bus.tries     = tries_q;
  assign bus.score     = score_q;
  assign bus.busy      = busy_q;
  assign bus.game_won  = won_q;
  assign bus.game_lost = lost_q;

endmodule

// File: tb/tb_game_level_sequencer.sv
// Randomized self-checking bench for game_level_sequencer against a game-level model.
module tb_game_level_sequencer;

  localparam int unsigned MAX_TRIES  = 4;
  localparam int unsigned SETTLE_CYC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_level_sequencer_if bus ();

  game_level_sequencer #(
    .MAX_TRIES  (MAX_TRIES),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model of the game: current level, attempts used, score, and how it ended.
  int m_lvl, m_tr, m_sc, m_end;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_draw"},  32'(bus.draw), 0);
    chk({tag, "_level"}, 32'(bus.level_sel), 0);
    chk({tag, "_sw"},    32'(bus.sw_cfg), 0);
    chk({tag, "_tries"}, 32'(bus.tries), 0);
    chk({tag, "_score"}, 32'(bus.score), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_won"},   32'(bus.game_won), 0);
    chk({tag, "_lost"},  32'(bus.game_lost), 0);
  endtask

  // mode: 0 random, 1 always pass, 2 always fail, 3 L1 try1 / L2 try3, 4 pass with sw_req=11
  task automatic play_game(input int mode, input int abort_lvl);
    logic       p;
    logic [1:0] sw, exp_sw;
    logic [2:0] pv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_lvl = 1; m_tr = 0; m_sc = 0; m_end = 0;
    while (m_end == 0) begin
      chk("draw_strobe",   32'(bus.draw), 1);
      chk("level_at_draw", 32'(bus.level_sel), 32'(m_lvl));
      chk("tries_at_draw", 32'(bus.tries), 32'(m_tr));
      chk("score_at_draw", 32'(bus.score), 32'(m_sc));
      chk("busy_draw",     32'(bus.busy), 1);
      if (mode == 3 && m_lvl == 3) chk("score_l3_entry", 32'(bus.score), 6);
      sw = (mode == 4) ? 2'b11 : 2'($urandom);
      bus.sw_req  = sw;
      exp_sw[0]   = sw[0] && (m_lvl >= 2);
      exp_sw[1]   = sw[1] && (m_lvl == 3);
      bus.pass_in = 3'($urandom);
      for (int s = 0; s < int'(SETTLE_CYC); s++) begin
        tick();
        chk("draw_one_cycle", 32'(bus.draw), 0);
        chk("busy_settle",    32'(bus.busy), 1);
        if (m_lvl == abort_lvl) begin
          bus.abort = 1'b1;
          tick();
          bus.abort = 1'b0;
          m_end = 3;
          break;
        end
        if (mode != 4) bus.sw_req = 2'($urandom);
        bus.pass_in = 3'($urandom);
        bus.start   = 1'($urandom);
      end
      if (m_end == 3) break;
      tick();
      bus.start = 1'b0;
      m_tr++;
      chk("tries_at_check", 32'(bus.tries), 32'(m_tr));
      chk("sw_cfg",         32'(bus.sw_cfg), 32'(exp_sw));
      chk("busy_check",     32'(bus.busy), 1);
      chk("score_in_check", 32'(bus.score), 32'(m_sc));
      case (mode)
        1, 4:    p = 1'b1;
        2:       p = 1'b0;
        3:       p = (m_lvl == 1) ? 1'b1 : (m_lvl == 2) ? (m_tr == 3) : 1'($urandom);
        default: p = 1'($urandom);
      endcase
      pv = 3'($urandom);
      pv[m_lvl-1] = p;
      bus.pass_in = pv;
      tick();
      if (p) begin
        m_sc = m_sc + int'(MAX_TRIES) - m_tr + 1;
        if (m_sc > 255) m_sc = 255;
        if (m_lvl == 3) m_end = 1;
        else begin
          m_lvl++;
          m_tr = 0;
        end
      end else if (m_tr == int'(MAX_TRIES)) begin
        m_end = 2;
      end
    end
    if (m_end == 3) begin
      chk("abort_level", 32'(bus.level_sel), 0);
      chk("abort_tries", 32'(bus.tries), 0);
      chk("abort_sw",    32'(bus.sw_cfg), 0);
      chk("abort_busy",  32'(bus.busy), 0);
      chk("abort_flags", 32'({bus.game_won, bus.game_lost}), 0);
      chk("abort_score", 32'(bus.score), 32'(m_sc));
    end else begin
      for (int h = 0; h < 3; h++) begin
        chk("end_won",   32'(bus.game_won), 32'(m_end == 1));
        chk("end_lost",  32'(bus.game_lost), 32'(m_end == 2));
        chk("end_score", 32'(bus.score), 32'(m_sc));
        chk("end_level", 32'(bus.level_sel), 32'(m_lvl));
        chk("end_tries", 32'(bus.tries), 32'(m_tr));
        chk("end_idle",  32'({bus.busy, bus.draw}), 0);
        bus.pass_in = 3'($urandom);
        bus.sw_req  = 2'($urandom);
        tick();
      end
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pass_in = 3'b000;
    bus.sw_req  = 2'b00;
    repeat (2) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    play_game(1, 0);
    play_game(2, 0);
    play_game(3, 0);
    play_game(4, 0);
    play_game(1, 2);

    // abort and start together from IDLE: abort wins
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_start_busy",  32'(bus.busy), 0);
    chk("abort_start_draw",  32'(bus.draw), 0);
    chk("abort_start_level", 32'(bus.level_sel), 0);
    chk("score_held_idle",   32'(bus.score), 32'(m_sc));

    // asynchronous reset in the middle of SETTLE
    bus.sw_req = 2'b11;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("pre_reset_busy", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("after_reset");
    play_game(1, 0);

    repeat (30) play_game(0, int'($urandom_range(0, 12)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
